pipe_stage_skid: RTL

Parametrised successor to the fixed-width EX/MEM stage register. It is a two-entry pipeline stage (main register plus skid register) with a valid/ready handshake on both sides, synchronous flush, and bubble (NOP) control insertion. Flag capture is selective. It sits between any two pipeline stages (EX/MEM, MEM/WB) so that back-pressure from a stalled downstream stage never drops an in-flight instruction.

---
 rtl/pipe_stage_skid_if.sv | 40 ++++
 rtl/pipe_stage_skid.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bus for a two-entry pipeline stage: upstream (in_*) and
// downstream (out_*) sides bundled together. The stage uses the slave view;
// the surrounding environment uses the master view.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int DST_W  = 4,
    parameter int FLAG_W = 3
);
    // Upstream side
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [DST_W-1:0]  in_dst;
    logic [FLAG_W-1:0] in_flags;
    logic              in_flags_wen;

    // Downstream side
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [DST_W-1:0]  out_dst;
    logic [FLAG_W-1:0] out_flags;

    modport master (
        output in_valid, in_ctrl, in_data, in_dst, in_flags, in_flags_wen,
        output out_ready,
        input  in_ready,
        input  out_valid, out_ctrl, out_data, out_dst, out_flags
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, in_dst, in_flags, in_flags_wen,
        input  out_ready,
        output in_ready,
        output out_valid, out_ctrl, out_data, out_dst, out_flags
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage (main + skid register) with valid/ready on both
// sides, synchronous flush, NOP control insertion on empty output and flag
// resolution against a shadow of the last written flags.
module pipe_stage_skid #(
    parameter int                DATA_W   = 16,
    parameter int                CTRL_W   = 8,
    parameter int                DST_W    = 4,
    parameter int                FLAG_W   = 3,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active low
    input  logic                flush,
    pipe_stage_skid_if.slave    bus,
    output logic [1:0]          occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [DST_W-1:0]  dst;
        logic [FLAG_W-1:0] flags;
    } entry_t;

    state_e            state_q, state_d;
    entry_t            main_q,  main_d;
    entry_t            skid_q,  skid_d;
    logic [FLAG_W-1:0] shadow_q, shadow_d;

    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   pop;
    entry_t in_entry;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);

    // Ready depends only on registered state, so no out_ready -> in_ready path.
    assign bus.in_ready = !skid_valid;

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = main_valid & bus.out_ready;

    // Flags are resolved on entry: a writing instruction carries its own
    // flags, anything else inherits the most recent written value.
    assign in_entry = '{
        ctrl:  bus.in_ctrl,
        data:  bus.in_data,
        dst:   bus.in_dst,
        flags: bus.in_flags_wen ? bus.in_flags : shadow_q
    };

    // Next-state and datapath steering for the EMPTY/ONE/FULL occupancy FSM.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        shadow_d = shadow_q;

        if (flush) begin
            // Squash everything held and anything arriving this cycle; the
            // shadow keeps its value because discarded entries never happened.
            state_d = EMPTY;
        end else begin
            if (accept && bus.in_flags_wen) begin
                shadow_d = bus.in_flags;
            end

            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_d = FULL;
                        skid_d  = in_entry;
                    end else if (accept && pop) begin
                        main_d  = in_entry;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid drains into main, preserving FIFO order.
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and entry registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: payload registers are cleared too, because the visible outputs must read zero out of reset.
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            shadow_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            shadow_q <= shadow_d;
        end
    end

    // Outputs come straight from the main register; only ctrl is masked.
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_valid ? main_q.ctrl : NOP_CTRL;
    assign bus.out_data  = main_q.data;
    assign bus.out_dst   = main_q.dst;
    assign bus.out_flags = main_q.flags;

    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
